// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - CSR addresses, cause codes, mstatus fields and FSM states for the trap sequencer
package trap_pkg;

   // Machine-mode CSR addresses
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   // mcause encodings; bit 31 marks an interrupt
   localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;
   localparam logic [31:0] CAUSE_MSI     = 32'h8000_0003;
   localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
   localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
   localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;

   // mstatus field positions
   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;
   localparam int MPP_LO   = 11;
   localparam int MPP_HI   = 12;

   // mip / mie bit positions of the three interrupt lines
   localparam int MSIP_BIT = 3;
   localparam int MTIP_BIT = 7;
   localparam int MEIP_BIT = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_T_EPC,
      ST_T_CAUSE,
      ST_T_STAT,
      ST_REDIR,
      ST_R_EPC,
      ST_R_STAT
   } state_t;

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - ranks interrupts and synchronous exceptions into take/is_irq/cause
module trap_prio_enc
   import trap_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_valid,
   input  logic            i_mstatus_mie,
   input  logic            i_any_pend,
   input  logic            i_meip_pend,
   input  logic            i_msip_pend,
   input  logic            i_mtip_pend,
   input  logic            i_illegal,
   input  logic            i_ecall,
   output logic            o_take,
   output logic            o_is_irq,
   output logic [XLEN-1:0] o_cause
);

   // Interrupts beat exceptions; among interrupts external > software > timer
   always_comb begin
      o_take   = 1'b0;
      o_is_irq = 1'b0;
      o_cause  = '0;
      if (i_valid) begin
         if (i_mstatus_mie && i_any_pend) begin
            o_take   = 1'b1;
            o_is_irq = 1'b1;
            if (i_meip_pend)      o_cause = XLEN'(CAUSE_MEI);
            else if (i_msip_pend) o_cause = XLEN'(CAUSE_MSI);
            else                  o_cause = XLEN'(CAUSE_MTI);
         end else if (i_illegal) begin
            o_take  = 1'b1;
            o_cause = XLEN'(CAUSE_ILLEGAL);
         end else if (i_ecall) begin
            o_take  = 1'b1;
            o_cause = XLEN'(CAUSE_ECALL);
         end
      end
   end

endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - machine-mode trap entry / MRET sequencer driving the CSR file
module trap_controller
   import trap_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_instr_valid,
   input  logic [XLEN-1:0]   i_pc,
   input  logic              i_illegal_instr,
   input  logic              i_ecall,
   input  logic              i_mret,
   input  logic              i_msip,
   input  logic              i_mtip,
   input  logic              i_meip,
   input  logic              i_mstatus_mie,
   input  logic [XLEN-1:0]   i_mie,
   output logic [XLEN-1:0]   o_mip,
   output logic [CSR_AW-1:0] o_csr_raddr,
   input  logic [XLEN-1:0]   i_csr_rdata,
   output logic              o_csr_we,
   output logic [CSR_AW-1:0] o_csr_waddr,
   output logic [XLEN-1:0]   o_csr_wdata,
   output logic              o_stall,
   output logic              o_redirect_valid,
   output logic [XLEN-1:0]   o_redirect_pc,
   output logic              o_busy
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_epc;
   logic [XLEN-1:0]   r_cause;
   logic              r_is_irq;
   logic [XLEN-1:0]   r_target;

   logic [XLEN-1:0]   w_pend;
   logic              w_take;
   logic              w_is_irq;
   logic [XLEN-1:0]   w_cause;
   logic              w_latch_trap;
   logic              w_latch_tgt;
   logic [XLEN-1:0]   w_tgt;
   logic [XLEN-1:0]   w_base;
   logic              w_we;
   logic              w_redir;

   // Pending lines straight from the wires; not touched by reset
   always_comb begin
      o_mip           = '0;
      o_mip[MSIP_BIT] = i_msip;
      o_mip[MTIP_BIT] = i_mtip;
      o_mip[MEIP_BIT] = i_meip;
   end

   assign w_pend = i_mie & o_mip;
   assign w_base = {i_csr_rdata[XLEN-1:2], 2'b00};

   trap_prio_enc #(.XLEN(XLEN)) u_prio (
      .i_valid       (i_instr_valid),
      .i_mstatus_mie (i_mstatus_mie),
      .i_any_pend    (|w_pend),
      .i_meip_pend   (w_pend[MEIP_BIT]),
      .i_msip_pend   (w_pend[MSIP_BIT]),
      .i_mtip_pend   (w_pend[MTIP_BIT]),
      .i_illegal     (i_illegal_instr),
      .i_ecall       (i_ecall),
      .o_take        (w_take),
      .o_is_irq      (w_is_irq),
      .o_cause       (w_cause)
   );

   // State register and the epc/cause/target latches
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_epc    <= '0;
         r_cause  <= '0;
         r_is_irq <= 1'b0;
         r_target <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch_trap) begin
            r_epc    <= i_pc;
            r_cause  <= w_cause;
            r_is_irq <= w_is_irq;
         end
         if (w_latch_tgt) r_target <= w_tgt;
      end
   end

   // Next state plus the per-state CSR access pattern, one write per state at most
   always_comb begin
      w_state_nxt   = r_state;
      w_latch_trap  = 1'b0;
      w_latch_tgt   = 1'b0;
      w_tgt         = '0;
      w_we          = 1'b0;
      w_redir       = 1'b0;
      o_stall       = 1'b1;
      o_csr_raddr   = '0;
      o_csr_waddr   = '0;
      o_csr_wdata   = '0;
      o_redirect_pc = '0;
      case (r_state)
         ST_IDLE: begin
            o_stall = 1'b0;
            if (w_take) begin
               o_stall      = 1'b1;
               w_latch_trap = 1'b1;
               w_state_nxt  = ST_T_EPC;
            end else if (i_instr_valid && i_mret) begin
               o_stall     = 1'b1;
               w_state_nxt = ST_R_EPC;
            end
         end
         ST_T_EPC: begin
            w_we        = 1'b1;
            o_csr_waddr = CSR_AW'(CSR_MEPC);
            o_csr_wdata = r_epc;
            o_csr_raddr = CSR_AW'(CSR_MTVEC);
            w_latch_tgt = 1'b1;
            if (i_csr_rdata[1:0] == 2'b01 && r_is_irq)
               w_tgt = w_base + {r_cause[XLEN-3:0], 2'b00};
            else
               w_tgt = w_base;
            w_state_nxt = ST_T_CAUSE;
         end
         ST_T_CAUSE: begin
            w_we        = 1'b1;
            o_csr_waddr = CSR_AW'(CSR_MCAUSE);
            o_csr_wdata = r_cause;
            w_state_nxt = ST_T_STAT;
         end
         ST_T_STAT: begin
            o_csr_raddr                 = CSR_AW'(CSR_MSTATUS);
            w_we                        = 1'b1;
            o_csr_waddr                 = CSR_AW'(CSR_MSTATUS);
            o_csr_wdata                 = i_csr_rdata;
            o_csr_wdata[MPIE_BIT]       = i_csr_rdata[MIE_BIT];
            o_csr_wdata[MIE_BIT]        = 1'b0;
            o_csr_wdata[MPP_HI:MPP_LO]  = 2'b11;
            w_state_nxt                 = ST_REDIR;
         end
         ST_R_EPC: begin
            o_csr_raddr = CSR_AW'(CSR_MEPC);
            w_latch_tgt = 1'b1;
            w_tgt       = w_base;
            w_state_nxt = ST_R_STAT;
         end
         ST_R_STAT: begin
            o_csr_raddr           = CSR_AW'(CSR_MSTATUS);
            w_we                  = 1'b1;
            o_csr_waddr           = CSR_AW'(CSR_MSTATUS);
            o_csr_wdata           = i_csr_rdata;
            o_csr_wdata[MIE_BIT]  = i_csr_rdata[MPIE_BIT];
            o_csr_wdata[MPIE_BIT] = 1'b1;
            w_state_nxt           = ST_REDIR;
         end
         ST_REDIR: begin
            w_redir       = 1'b1;
            o_redirect_pc = r_target;
            w_state_nxt   = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // A reset landing mid-sequence must not let the pending write or redirect escape
   assign o_csr_we         = w_we & ~i_rst;
   assign o_redirect_valid = w_redir & ~i_rst;
   assign o_busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - scoreboard bench for trap_controller with a small CSR file model
module tb_trap_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid, illegal_instr, ecall, mret;
   logic        msip, mtip, meip;
   logic [31:0] pc, mie;
   logic        mstatus_mie;
   logic [31:0] mip;
   logic [11:0] csr_raddr, csr_waddr;
   logic [31:0] csr_rdata, csr_wdata;
   logic        csr_we, stall, redirect_valid, busy;
   logic [31:0] redirect_pc;

   logic        poke_we;
   logic [11:0] poke_addr;
   logic [31:0] poke_data;
   logic [31:0] csr_mem [0:4095];

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   trap_controller dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_instr_valid    (instr_valid),
      .i_pc             (pc),
      .i_illegal_instr  (illegal_instr),
      .i_ecall          (ecall),
      .i_mret           (mret),
      .i_msip           (msip),
      .i_mtip           (mtip),
      .i_meip           (meip),
      .i_mstatus_mie    (mstatus_mie),
      .i_mie            (mie),
      .o_mip            (mip),
      .o_csr_raddr      (csr_raddr),
      .i_csr_rdata      (csr_rdata),
      .o_csr_we         (csr_we),
      .o_csr_waddr      (csr_waddr),
      .o_csr_wdata      (csr_wdata),
      .o_stall          (stall),
      .o_redirect_valid (redirect_valid),
      .o_redirect_pc    (redirect_pc),
      .o_busy           (busy)
   );

   // CSR file model: combinational read, DUT writes win over bench preloads
   always @(posedge clk) begin
      if (csr_we)       csr_mem[csr_waddr] <= csr_wdata;
      else if (poke_we) csr_mem[poke_addr] <= poke_data;
   end
   assign csr_rdata   = csr_mem[csr_raddr];
   assign mstatus_mie = csr_mem[12'h300][3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic push_w(input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.kind = 0; e.addr = a; e.data = d;
      sb.push_back(e);
   endtask

   task automatic push_r(input logic [31:0] d);
      exp_t e;
      e.kind = 1; e.addr = 32'h0; e.data = d;
      sb.push_back(e);
   endtask

   // Every CSR write and redirect pulse the DUT produces is matched against the queue
   always @(negedge clk) begin
      exp_t e;
      if (csr_we) begin
         if (sb.size() == 0) check("sb_unexp_we", sb.size(), 1);
         else begin
            e = sb.pop_front();
            check("sb_kind_we", 0, e.kind);
            check("sb_waddr", {20'd0, csr_waddr}, e.addr);
            check("sb_wdata", csr_wdata, e.data);
         end
      end
      if (redirect_valid) begin
         if (sb.size() == 0) check("sb_unexp_redir", sb.size(), 1);
         else begin
            e = sb.pop_front();
            check("sb_kind_redir", 1, e.kind);
            check("sb_redir_pc", redirect_pc, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [11:0] a, input logic [31:0] d);
      poke_we = 1'b1; poke_addr = a; poke_data = d;
      tick();
      poke_we = 1'b0;
   endtask

   task automatic clr_events();
      instr_valid = 0; illegal_instr = 0; ecall = 0; mret = 0;
      msip = 0; mtip = 0; meip = 0;
   endtask

   // Stimulus already applied; n stall cycles then the redirect pulse in cycle n+1
   task automatic run_seq(input string nm, input int n, input bit hold_ecall);
      for (int c = 1; c <= n + 1; c++) begin
         @(negedge clk);
         if (c <= n) check({nm, "_stall"}, {31'd0, stall}, 32'd1);
         check({nm, "_redir_timing"}, {31'd0, redirect_valid}, (c == n + 1) ? 32'd1 : 32'd0);
         tick();
         if (c == 1 && !hold_ecall) clr_events();
         if (c == 1 && hold_ecall) begin msip = 0; mtip = 0; meip = 0; end
      end
      clr_events();
      @(negedge clk);
      check({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
      check({nm, "_sb_drain"}, sb.size(), 0);
      tick();
   endtask

   initial begin
      rst = 1; clr_events(); pc = 0; mie = 0;
      poke_we = 0; poke_addr = 0; poke_data = 0;

      // Reset state
      tick();
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_stall", {31'd0, stall}, 0);
      check("rst_we", {31'd0, csr_we}, 0);
      check("rst_redir", {31'd0, redirect_valid}, 0);
      check("rst_waddr", {20'd0, csr_waddr}, 0);
      check("rst_wdata", csr_wdata, 0);
      check("rst_rpc", redirect_pc, 0);
      check("rst_mip", mip, 0);
      tick();
      rst = 0;

      // mip packing, instr_valid low so nothing is taken
      meip = 1; mtip = 1;
      @(negedge clk);
      check("mip_pack", mip, 32'h0000_0880);
      tick();
      clr_events();

      // 1: illegal instruction, direct mtvec
      poke(12'h305, 32'h0000_0100);
      poke(12'h300, 32'h0000_0008);
      push_w(32'h341, 32'h40); push_w(32'h342, 32'h2); push_w(32'h300, 32'h1880); push_r(32'h100);
      pc = 32'h40; illegal_instr = 1; instr_valid = 1;
      run_seq("illegal", 4, 0);
      check("illegal_mepc", csr_mem[12'h341], 32'h40);
      check("illegal_mstatus", csr_mem[12'h300], 32'h1880);

      // 2: vectored timer interrupt
      poke(12'h305, 32'h0000_0201);
      poke(12'h300, 32'h0000_0008);
      mie = 32'h80;
      push_w(32'h341, 32'h80); push_w(32'h342, 32'h8000_0007); push_w(32'h300, 32'h1880); push_r(32'h21C);
      pc = 32'h80; mtip = 1; instr_valid = 1;
      run_seq("vec_tmr", 4, 0);

      // 3: masked timer interrupt, then unmasked
      mtip = 1; instr_valid = 1; pc = 32'h90;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("mask_stall", {31'd0, stall}, 0);
         check("mask_we", {31'd0, csr_we}, 0);
         tick();
      end
      instr_valid = 0;
      poke(12'h300, 32'h0000_0008);
      push_w(32'h341, 32'h90); push_w(32'h342, 32'h8000_0007); push_w(32'h300, 32'h1880); push_r(32'h21C);
      instr_valid = 1;
      run_seq("unmask", 4, 0);

      // 4: meip + msip + ecall together; ecall held through the sequence must not be queued
      poke(12'h305, 32'h0000_0100);
      poke(12'h300, 32'h0000_0008);
      mie = 32'h888;
      push_w(32'h341, 32'hA0); push_w(32'h342, 32'h8000_000B); push_w(32'h300, 32'h1880); push_r(32'h100);
      pc = 32'hA0; meip = 1; msip = 1; ecall = 1; instr_valid = 1;
      run_seq("simul", 4, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("simul_noqueue", {31'd0, stall | busy}, 0);
         tick();
      end

      // 5: MRET
      poke(12'h341, 32'h0000_0044);
      poke(12'h300, 32'h0000_1880);
      push_w(32'h300, 32'h1888); push_r(32'h44);
      pc = 32'hB0; mret = 1; instr_valid = 1;
      run_seq("mret", 3, 0);
      check("mret_mie", {31'd0, csr_mem[12'h300][3]}, 1);
      check("mret_mpie", {31'd0, csr_mem[12'h300][7]}, 1);

      // 6: reset during T_CAUSE
      poke(12'h300, 32'h0000_0008);
      poke(12'h342, 32'h0000_0055);
      push_w(32'h341, 32'hC0);
      pc = 32'hC0; illegal_instr = 1; instr_valid = 1;
      @(negedge clk);
      check("rstmid_stall", {31'd0, stall}, 1);
      tick();
      clr_events();
      @(negedge clk);
      check("rstmid_epc_we", {31'd0, csr_we}, 1);
      tick();
      rst = 1;
      @(negedge clk);
      check("rstmid_we_blocked", {31'd0, csr_we}, 0);
      tick();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rstmid_busy", {31'd0, busy}, 0);
         check("rstmid_redir", {31'd0, redirect_valid}, 0);
         tick();
      end
      check("rstmid_sb_drain", sb.size(), 0);
      check("rstmid_mcause", csr_mem[12'h342], 32'h55);
      check("rstmid_mstatus", csr_mem[12'h300], 32'h8);
      check("rstmid_mepc", csr_mem[12'h341], 32'hC0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
Machine-mode trap sequencer for the single-cycle RV32 processor. It sits between the core's decode/PC logic and the CSR register file. It detects interrupts, illegal instructions, ECALL and MRET at the instruction boundary, then stalls the core. It runs a fixed-order sequence of CSR reads and writes (mepc, mcause, mstatus, mtvec) and finishes with a single-cycle PC redirect.

Parameters:
XLEN, 32, data/PC width
CSR_AW, 12, CSR address width

Ports:
clk  in  1  clock, single domain
rst  in  1  reset, synchronous, active-high
instr_valid  in  1  the current instruction is valid and about to commit
pc  in  XLEN  PC of the current instruction
illegal_instr  in  1  decoder flag: illegal instruction
ecall  in  1  decoder flag: ECALL
mret  in  1  decoder flag: MRET
msip  in  1  software interrupt line, level
mtip  in  1  timer interrupt line, level
meip  in  1  external interrupt line, level
mstatus_mie  in  1  direct tap of mstatus[3]
mie  in  XLEN  direct tap of the mie CSR
mip  out  XLEN  pending bits {meip@11, mtip@7, msip@3}, others 0; feeds the CSR file
csr_raddr  out  CSR_AW  CSR read address
csr_rdata  in  XLEN  CSR read data, combinational, same cycle
csr_we  out  1  CSR write enable
csr_waddr  out  CSR_AW  CSR write address
csr_wdata  out  XLEN  CSR write data
stall  out  1  hold the PC and suppress the register-file and dmem writes
redirect_valid  out  1  one-cycle pulse: load redirect_pc
redirect_pc  out  XLEN  new PC
busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: all state is on clk. rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - csr_we, redirect_valid, stall and busy are 0.
  - All address and data outputs and internal latches are 0.
  - mip is combinational from the lines and is unaffected by reset.
- Interrupt qualification: irq_take = mstatus_mie & |(mie & mip).
- Priority, evaluated in IDLE only when instr_valid = 1:
  - interrupt (meip > msip > mtip) > illegal_instr > ecall > mret.
- Cause encodings:
  - meip: 0x8000000B; msip: 0x80000003; mtip: 0x80000007.
  - illegal_instr: 0x00000002; ecall: 0x0000000B.
- IDLE:
  - stall is asserted combinationally in the detection cycle, so the faulting instruction never commits.
  - On a trap, latch epc = pc and cause, then go to T_EPC.
  - On mret alone, go to R_EPC.
  - Otherwise stay in IDLE, with stall = 0.
- Trap sequence (stall = 1 in every state):
  - T_EPC: write 0x341 (mepc) with epc. Read 0x305 (mtvec) and latch the target:
    - vectored mode (mtvec[1:0] = 01) and cause is an interrupt: target = {mtvec[31:2],2'b00} + 4*cause[30:0];
    - otherwise: target = {mtvec[31:2],2'b00}.
  - T_CAUSE: write 0x342 (mcause) with cause.
  - T_STAT: read 0x300 (mstatus) and write it back with MPIE(bit7) = MIE(bit3), MIE = 0, MPP(12:11) = 2'b11.
  - REDIR: redirect_valid = 1, redirect_pc = target, then go to IDLE.
- MRET sequence:
  - R_EPC: read 0x341 and latch target = {mepc[31:2],2'b00}. No write in this state.
  - R_STAT: write mstatus with MIE = MPIE, MPIE = 1.
  - Then REDIR.
- Latency, detection cycle to redirect pulse:
  - trap: 4 cycles; the pulse is in the 5th cycle;
  - MRET: 3 cycles.
- csr_we is high in exactly one cycle per write; at most one write per cycle.
- Events while busy: ignored; they are not queued. Level interrupts are re-evaluated after returning to IDLE. The first IDLE cycle after REDIR sees the already-updated MIE.
- instr_valid = 0 in IDLE: nothing is taken, including pending interrupts.
- Interrupt sources are never cleared by this block; software clears the source.
- rst mid-sequence: IDLE on the next edge; no further CSR writes; CSRs already written keep their values.

Decomposition:
- Package trap_pkg holds:
  - the CSR address constants (MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MIP 0x344);
  - the cause codes;
  - the bit positions (MIE = 3, MPIE = 7, MPP = 12:11);
  - a state_t enum.
- Optional sub-module trap_prio_enc: combinational priority encoder producing {take, is_irq, cause}.

Test Plan:
1. Illegal instruction:
   - Stimulus: pc = 0x00000040, illegal_instr = 1, mtvec = 0x00000100, mstatus = 0x8.
   - Response: mepc = 0x40, mcause = 2, mstatus = 0x1880, redirect_pc = 0x100 in cycle 5; stall high in cycles 1-4.
2. Vectored timer interrupt:
   - Stimulus: mtvec = 0x00000201, mie = 0x80, mtip = 1, MIE = 1.
   - Response: mcause = 0x80000007, redirect_pc = 0x21C.
3. Masking:
   - Stimulus: mtip = 1 with MIE = 0.
   - Response: no stall, no csr_we for 20 cycles. Setting MIE = 1 afterwards triggers the trap.
4. Simultaneous events:
   - Stimulus: meip + msip + ecall asserted together, mie = 0x888.
   - Response: mcause = 0x8000000B; ecall is lost and is not queued.
5. MRET:
   - Stimulus: mepc = 0x00000044, mstatus = 0x1880, mret = 1.
   - Response: mstatus[3] = 1, mstatus[7] = 1, redirect_pc = 0x44 on the 4th cycle.
6. Reset mid-sequence:
   - Stimulus: rst asserted during T_CAUSE.
   - Response: mcause unwritten, mstatus unchanged, busy = 0 and redirect_valid = 0 from the next cycle.
